// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, default datapath width and the
// response-analyzer FSM state type.
package alu_pkg;

  localparam int unsigned AluDataW = 4;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDiv = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } ana_state_e;

endpackage

// File: rtl/alu_misr.sv
// Multiple-input signature register compacting ALU results; the feedback
// taps implement x^4+x+1 at the default width, seeded with zero.
module alu_misr #(
  parameter int unsigned DATA_W = alu_pkg::AluDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] c_in,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] sig_q, sig_d;
  logic [DATA_W-1:0] rotated, feedback;

  // Rotate brings s[msb] into bit 0; the extra tap folds it into bit 1 too.
  always_comb begin
    rotated  = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]};
    feedback = '0;
    feedback[1] = sig_q[DATA_W-1];
    sig_d    = rotated ^ feedback ^ c_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_response_analyzer.sv
// Compares ALU results against expected values over a session of beats,
// counting mismatches and compacting results into a MISR signature.
module alu_response_analyzer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = AluDataW,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NV_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NV_W-1:0]   num_vectors,
  input  logic [DATA_W-1:0] golden_sig,
  input  logic              c_valid,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] exp_in,
  output logic              busy,
  output logic              done,
  output logic              fault_flag,
  output logic [CNT_W-1:0]  fault_count,
  output logic [DATA_W-1:0] signature,
  output logic              pass
);

  localparam logic [NV_W-1:0]  NvOne  = NV_W'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  ana_state_e state_q, state_d;

  logic [NV_W-1:0]   beat_cnt_q, nv_q;
  logic [DATA_W-1:0] golden_q;
  logic              fault_flag_q;
  logic [CNT_W-1:0]  fault_count_q;

  logic start_acc, beat_acc, last_beat, mismatch;

  assign start_acc = start && (state_q != StRun);
  assign beat_acc  = c_valid && (state_q == StRun);
  assign last_beat = beat_acc && ((beat_cnt_q + NvOne) == nv_q);
  assign mismatch  = (c_in != exp_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = (num_vectors == '0) ? StDone : StRun;
      end
      StRun: begin
        if (last_beat) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    pass = done && (fault_count_q == '0) && (signature == golden_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      nv_q          <= '0;
      golden_q      <= '0;
      fault_flag_q  <= 1'b0;
      fault_count_q <= '0;
    end else if (start_acc) begin
      beat_cnt_q    <= '0;
      nv_q          <= num_vectors;
      golden_q      <= golden_sig;
      fault_flag_q  <= 1'b0;
      fault_count_q <= '0;
    end else if (beat_acc) begin
      beat_cnt_q   <= beat_cnt_q + NvOne;
      fault_flag_q <= mismatch;
      if (mismatch && (fault_count_q != '1)) begin
        fault_count_q <= fault_count_q + CntOne;
      end
    end
  end

  alu_misr #(
    .DATA_W(DATA_W)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_acc),
    .en   (beat_acc),
    .c_in (c_in),
    .sig  (signature)
  );

  assign fault_flag  = fault_flag_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_alu_response_analyzer.sv
// Self-checking bench: directed session scenarios plus random traffic, checked
// every cycle against a session-level reference model.
module tb_alu_response_analyzer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_vectors = '0;
  logic [3:0] golden_sig = '0;
  logic       c_valid = 1'b0;
  logic [3:0] c_in = '0;
  logic [3:0] exp_in = '0;

  logic        busy, done, fault_flag, pass;
  logic [15:0] fault_count;
  logic [3:0]  signature;
  logic        busy_s, done_s, fault_flag_s, pass_s;
  logic [1:0]  fault_count_s;
  logic [3:0]  signature_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: session mode 0=idle 1=running 2=finished.
  int          m_mode = 0;
  int unsigned m_beats = 0, m_nv = 0, m_count = 0;
  logic [3:0]  m_gold = '0, m_sig = '0;
  logic        m_flag = 1'b0;

  always #5 clk = ~clk;

  alu_response_analyzer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .golden_sig(golden_sig), .c_valid(c_valid), .c_in(c_in), .exp_in(exp_in),
    .busy(busy), .done(done), .fault_flag(fault_flag), .fault_count(fault_count),
    .signature(signature), .pass(pass)
  );

  alu_response_analyzer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .golden_sig(golden_sig), .c_valid(c_valid), .c_in(c_in), .exp_in(exp_in),
    .busy(busy_s), .done(done_s), .fault_flag(fault_flag_s),
    .fault_count(fault_count_s), .signature(signature_s), .pass(pass_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo x^4+x+1, add c.
  function automatic logic [3:0] misr_ref(input logic [3:0] s, input logic [3:0] c);
    logic [4:0] t;
    t = {s, 1'b0};
    if (t[4]) t = t ^ 5'b10011;
    return t[3:0] ^ c;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned w);
    int unsigned lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_beats = 0; m_nv = 0; m_count = 0;
      m_gold = '0; m_sig = '0; m_flag = 1'b0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_beats = 0; m_count = 0; m_sig = '0; m_flag = 1'b0;
        m_nv = num_vectors; m_gold = golden_sig;
        m_mode = (num_vectors == 0) ? 2 : 1;
      end
    end else if (c_valid) begin
      m_flag = (c_in != exp_in);
      if (m_flag) m_count++;
      m_sig = misr_ref(m_sig, c_in);
      m_beats++;
      if (m_beats == m_nv) m_mode = 2;
    end
  endtask

  task automatic compare_all();
    logic m_pass;
    m_pass = (m_mode == 2) && (m_count == 0) && (m_sig == m_gold);
    check_eq("busy", busy, m_mode == 1);
    check_eq("done", done, m_mode == 2);
    check_eq("fault_flag", fault_flag, m_flag);
    check_eq("fault_count", fault_count, sat(m_count, 16));
    check_eq("signature", signature, m_sig);
    check_eq("pass", pass, m_pass);
    check_eq("sat_fault_count", fault_count_s, sat(m_count, 2));
    check_eq("sat_pass", pass_s, m_pass);
    check_eq("sat_done", done_s, m_mode == 2);
  endtask

  task automatic cycle(input logic s, input logic [7:0] nv, input logic [3:0] g,
                       input logic v, input logic [3:0] c, input logic [3:0] e);
    start = s; num_vectors = nv; golden_sig = g;
    c_valid = v; c_in = c; exp_in = e;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 8'd0, 4'd0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    idle_cycle();
    idle_cycle();
    check_eq("reset_count", fault_count, 0);
    rst_n = 1'b1;
    idle_cycle();

    // Three matching zero beats, golden 0
    cycle(1'b1, 8'd3, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h0, 4'h0);
    check_eq("s033_done", done, 1);
    check_eq("s033_pass", pass, 1);
    idle_cycle();

    // Single mismatching beat
    cycle(1'b1, 8'd1, 4'h0, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h5, 4'h6);
    check_eq("s034_flag", fault_flag, 1);
    check_eq("s034_count", fault_count, 1);
    check_eq("s034_pass", pass, 0);

    // Signature progression 0001 -> 0010
    cycle(1'b1, 8'd2, 4'h2, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h1, 4'h1);
    check_eq("s035_sig1", signature, 4'h1);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h0, 4'h0);
    check_eq("s035_sig2", signature, 4'h2);
    check_eq("s035_pass", pass, 1);

    // Saturation in the 2-bit counter
    cycle(1'b1, 8'd5, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'(i), 4'(i + 1));
    check_eq("s036_sat", fault_count_s, 2'b11);
    check_eq("s036_wide", fault_count, 5);

    // Zero-length session; beat offered afterwards must be ignored
    cycle(1'b1, 8'd0, 4'h0, 1'b1, 4'h3, 4'h4);
    check_eq("s037_done", done, 1);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h3, 4'h4);
    check_eq("s037_count", fault_count, 0);

    // Reset mid-session, then start/start-while-busy with c_valid held
    cycle(1'b1, 8'd4, 4'h0, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h7, 4'h1);
    cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h9, 4'h9);
    rst_n = 1'b0;
    idle_cycle();
    check_eq("s038_rst_sig", signature, 0);
    check_eq("s038_rst_busy", busy, 0);
    rst_n = 1'b1;
    cycle(1'b1, 8'd4, 4'h0, 1'b1, 4'hA, 4'hB);
    cycle(1'b1, 8'd2, 4'h0, 1'b1, 4'hA, 4'hB);
    check_eq("s038_busy", busy, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 4'h0, 1'b1, 4'h1, 4'h1);
    check_eq("s038_done", done, 1);
    check_eq("s038_count", fault_count, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] c, e;
      rst_n = ($urandom_range(0, 79) != 0);
      c = 4'($urandom);
      e = ($urandom_range(0, 1) != 0) ? c : 4'($urandom);
      cycle($urandom_range(0, 5) == 0, 8'($urandom_range(0, 6)), 4'($urandom),
            $urandom_range(0, 2) != 0, c, e);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
